// File: rtl/psec6_readout_sequencer.sv
// psec6_readout_sequencer: walks every enabled channel and counter index after an
// acquisition stops, fetches each counter word over a req/ack handshake and
// queues it MSB byte first into a small byte FIFO drained by the SPI read path.
module psec6_readout_sequencer #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned NUM_SEL    = 5,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              inst_readout,
    input  logic              inst_rst,
    input  logic              clk_enable,
    input  logic [NUM_CH-1:0] readout_mask,
    output logic [2:0]        ch_sel,
    output logic [2:0]        select_reg,
    output logic              ch_req,
    input  logic              ch_ack,
    input  logic [WORD_W-1:0] ch_data,
    input  logic              fifo_pop,
    output logic [7:0]        fifo_rdata,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic              cmd_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FIND, S_REQ, S_WAIT_ACK, S_PUSH_HI, S_PUSH_LO, S_NEXT, S_DONE
    } state_e;

    state_e            state_q;
    logic [2:0]        ch_sel_q;
    logic [2:0]        sel_q;
    logic              ch_req_q;
    logic              busy_q;
    logic              done_q;
    logic              cmd_err_q;
    logic [WORD_W-1:0] data_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              any_above;
    logic              ch_en;
    logic              last_ch;
    logic              last_sel;
    logic              full_w;
    logic              empty_w;
    logic              push_w;
    logic              pop_w;
    logic [7:0]        push_byte;

    // Channel scan helpers: is the current channel enabled, and is any enabled at or above it
    always_comb begin
        any_above = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i >= 32'(ch_sel_q) && readout_mask[i]) any_above = 1'b1;
        end
        ch_en    = readout_mask[ch_sel_q];
        last_ch  = (ch_sel_q == 3'(NUM_CH - 1));
        last_sel = (sel_q == 3'(NUM_SEL - 1));
    end

    // FIFO push/pop qualification; inst_rst overrides both
    always_comb begin
        full_w    = (count_q == CNT_W'(FIFO_DEPTH));
        empty_w   = (count_q == '0);
        push_w    = !inst_rst && !full_w && (state_q == S_PUSH_HI || state_q == S_PUSH_LO);
        pop_w     = !inst_rst && fifo_pop && !empty_w;
        push_byte = (state_q == S_PUSH_HI) ? data_q[WORD_W-1 -: 8] : data_q[7:0];
    end

    // Readout sequencer FSM with registered outputs
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ch_sel_q  <= '0;
            sel_q     <= '0;
            ch_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            data_q    <= '0;
        end else if (inst_rst) begin
            state_q   <= S_IDLE;
            ch_sel_q  <= '0;
            sel_q     <= '0;
            ch_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_readout) begin
                        if (clk_enable) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            done_q    <= 1'b0;
                            cmd_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            ch_sel_q  <= '0;
                            sel_q     <= '0;
                            state_q   <= S_FIND;
                        end
                    end
                end
                S_FIND: begin
                    if (ch_en)           state_q  <= S_REQ;
                    else if (!any_above) state_q  <= S_DONE;
                    else                 ch_sel_q <= ch_sel_q + 3'd1;
                end
                S_REQ: begin
                    if (!ch_ack) begin
                        ch_req_q <= 1'b1;
                        state_q  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (ch_ack) begin
                        data_q   <= ch_data;
                        ch_req_q <= 1'b0;
                        state_q  <= S_PUSH_HI;
                    end
                end
                S_PUSH_HI: if (!full_w) state_q <= S_PUSH_LO;
                S_PUSH_LO: if (!full_w) state_q <= S_NEXT;
                S_NEXT: begin
                    if (!last_sel) begin
                        sel_q   <= sel_q + 3'd1;
                        state_q <= S_REQ;
                    end else if (last_ch) begin
                        state_q <= S_DONE;
                    end else begin
                        sel_q    <= '0;
                        ch_sel_q <= ch_sel_q + 3'd1;
                        state_q  <= S_FIND;
                    end
                end
                S_DONE: begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    ch_sel_q <= '0;
                    sel_q    <= '0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (inst_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_w, pop_w})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the read port is masked when empty
    always_ff @(posedge spi_clk) begin
        if (push_w) mem_q[wr_ptr_q] <= push_byte;
    end

    assign ch_sel     = ch_sel_q;
    assign select_reg = sel_q;
    assign ch_req     = ch_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_err    = cmd_err_q;
    assign fifo_empty = empty_w;
    assign fifo_full  = full_w;
    assign fifo_rdata = empty_w ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_psec6_readout_sequencer.sv
// Directed bench for psec6_readout_sequencer: a channel responder returns
// {0,ch,0,sel,8'hA5} per request, a popper drains the FIFO and records bytes.
module tb_psec6_readout_sequencer;

    logic        spi_clk;
    logic        rstn;
    logic        inst_readout;
    logic        inst_rst;
    logic        clk_enable;
    logic [7:0]  readout_mask;
    logic [2:0]  ch_sel;
    logic [2:0]  select_reg;
    logic        ch_req;
    logic        ch_ack;
    logic [15:0] ch_data;
    logic        fifo_pop;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        fifo_full;
    logic        busy;
    logic        done;
    logic        cmd_err;

    int total = 0;
    int bad   = 0;

    logic       pop_en    = 1'b0;
    logic       ack_block = 1'b0;
    logic [2:0] block_sel = 3'd0;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];

    psec6_readout_sequencer #(
        .NUM_CH(8), .NUM_SEL(5), .WORD_W(16), .FIFO_DEPTH(4)
    ) dut (
        .spi_clk(spi_clk), .rstn(rstn), .inst_readout(inst_readout), .inst_rst(inst_rst),
        .clk_enable(clk_enable), .readout_mask(readout_mask), .ch_sel(ch_sel),
        .select_reg(select_reg), .ch_req(ch_req), .ch_ack(ch_ack), .ch_data(ch_data),
        .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    initial begin
        spi_clk = 1'b0;
        forever #5 spi_clk = ~spi_clk;
    end

    // Channel responder: one-cycle ack to each request, optionally withheld
    initial begin
        ch_ack  = 1'b0;
        ch_data = 16'h0;
        forever begin
            @(posedge spi_clk);
            #2;
            if (!rstn) begin
                ch_ack = 1'b0;
            end else if (ch_ack) begin
                ch_ack = 1'b0;
            end else if (ch_req && !(ack_block && select_reg == block_sel)) begin
                ch_ack  = 1'b1;
                ch_data = {1'b0, ch_sel, 1'b0, select_reg, 8'hA5};
            end
        end
    end

    // FIFO popper: pops whenever enabled and non-empty, logging the head byte
    initial begin
        fifo_pop = 1'b0;
        forever begin
            @(posedge spi_clk);
            #2;
            if (pop_en && rstn && !fifo_empty) begin
                fifo_pop = 1'b1;
                rx.push_back(fifo_rdata);
            end else begin
                fifo_pop = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic pulse_readout();
        inst_readout = 1'b1;
        tick();
        inst_readout = 1'b0;
    endtask

    task automatic build_exp(input logic [7:0] m);
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                for (int s = 0; s < 5; s++) begin
                    logic [2:0] c3;
                    logic [2:0] s3;
                    c3 = 3'(c);
                    s3 = 3'(s);
                    exp_q.push_back({1'b0, c3, 1'b0, s3});
                    exp_q.push_back(8'hA5);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; inst_readout = 1'b0; inst_rst = 1'b0; clk_enable = 1'b0; readout_mask = 8'h00;
        repeat (3) tick();
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (cmd_err !== 1'b0)     begin bad++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        total++; if (ch_req !== 1'b0)      begin bad++; $display("FAIL reset_ch_req got=%b exp=0", ch_req); end
        total++; if (ch_sel !== 3'd0)      begin bad++; $display("FAIL reset_ch_sel got=%0d exp=0", ch_sel); end
        total++; if (select_reg !== 3'd0)  begin bad++; $display("FAIL reset_select_reg got=%0d exp=0", select_reg); end
        total++; if (fifo_empty !== 1'b1)  begin bad++; $display("FAIL reset_fifo_empty got=%b exp=1", fifo_empty); end
        total++; if (fifo_full !== 1'b0)   begin bad++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
        total++; if (fifo_rdata !== 8'h00) begin bad++; $display("FAIL reset_fifo_rdata got=%h exp=00", fifo_rdata); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_mask05();
        int n;
        readout_mask = 8'h05; clk_enable = 1'b0; pop_en = 1'b1; rx.delete();
        build_exp(8'h05);
        pulse_readout();
        total++; if (busy !== 1'b1)   begin bad++; $display("FAIL m05_busy_latency got=%b exp=1", busy); end
        total++; if (ch_sel !== 3'd0) begin bad++; $display("FAIL m05_start_ch got=%0d exp=0", ch_sel); end
        tick();
        total++; if (ch_req !== 1'b0) begin bad++; $display("FAIL m05_req_early got=%b exp=0", ch_req); end
        tick();
        total++; if (ch_req !== 1'b1) begin bad++; $display("FAIL m05_req_latency got=%b exp=1", ch_req); end
        repeat (3) tick();
        // readout while busy with clk_enable raised: ignored, no cmd_err
        clk_enable = 1'b1;
        pulse_readout();
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL m05_busy_readout_err got=%b exp=0", cmd_err); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL m05_still_busy got=%b exp=1", busy); end
        n = 0;
        while (!done && n < 400) begin tick(); n++; end
        total++; if (done !== 1'b1)       begin bad++; $display("FAIL m05_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL m05_busy_end got=%b exp=0", busy); end
        total++; if (ch_sel !== 3'd0)     begin bad++; $display("FAIL m05_ch_sel_end got=%0d exp=0", ch_sel); end
        total++; if (select_reg !== 3'd0) begin bad++; $display("FAIL m05_sel_end got=%0d exp=0", select_reg); end
        clk_enable = 1'b0;
        repeat (6) tick();
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL m05_drained got=%b exp=1", fifo_empty); end
        total++; if (rx.size() != 20) begin bad++; $display("FAIL m05_count got=%0d exp=20", rx.size()); end
        for (int i = 0; i < 20 && i < rx.size(); i++) begin
            total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL m05_byte[%0d] got=%h exp=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_mask();
        int n;
        bit saw_req;
        readout_mask = 8'h00; rx.delete(); saw_req = 0;
        pulse_readout();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL m00_done_cleared got=%b exp=0", done); end
        n = 0;
        while (!done && n < 3) begin tick(); n++; if (ch_req) saw_req = 1; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL m00_done got=%b exp=1 after %0d cycles", done, n); end
        total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL m00_no_req got=%b exp=0", saw_req); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL m00_fifo_empty got=%b exp=1", fifo_empty); end
        total++; if (rx.size() != 0) begin bad++; $display("FAIL m00_no_bytes got=%0d exp=0", rx.size()); end
    endtask

    task automatic test_cmd_err();
        clk_enable = 1'b1; readout_mask = 8'h05;
        pulse_readout();
        total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", cmd_err); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL err_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b1)    begin bad++; $display("FAIL err_done_kept got=%b exp=1", done); end
        tick();
        total++; if (ch_req !== 1'b0)  begin bad++; $display("FAIL err_no_req got=%b exp=0", ch_req); end
        clk_enable = 1'b0; readout_mask = 8'h00;
        pulse_readout();
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", cmd_err); end
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL err_accept_busy got=%b exp=1", busy); end
        repeat (4) tick();
    endtask

    task automatic test_stall();
        int n;
        pop_en = 1'b0; readout_mask = 8'h80; rx.delete();
        build_exp(8'h80);
        pulse_readout();
        n = 0;
        while (!fifo_full && n < 100) begin tick(); n++; end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL st_full got=%b exp=1", fifo_full); end
        repeat (10) tick();
        total++; if (fifo_full !== 1'b1)   begin bad++; $display("FAIL st_full_hold got=%b exp=1", fifo_full); end
        total++; if (ch_req !== 1'b0)      begin bad++; $display("FAIL st_req_low got=%b exp=0", ch_req); end
        total++; if (busy !== 1'b1)        begin bad++; $display("FAIL st_busy got=%b exp=1", busy); end
        total++; if (fifo_rdata !== 8'h70) begin bad++; $display("FAIL st_head got=%h exp=70", fifo_rdata); end
        total++; if (select_reg !== 3'd2)  begin bad++; $display("FAIL st_sel got=%0d exp=2", select_reg); end
        pop_en = 1'b1;
        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL st_done got=%b exp=1", done); end
        repeat (6) tick();
        total++; if (rx.size() != 10) begin bad++; $display("FAIL st_count got=%0d exp=10", rx.size()); end
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL st_byte[%0d] got=%h exp=%h", i, rx[i], exp_q[i]); end
        end
    endtask

    task automatic test_inst_rst();
        int n;
        pop_en = 1'b0; readout_mask = 8'h08; ack_block = 1'b1; block_sel = 3'd1;
        pulse_readout();
        n = 0;
        while (!(ch_req && select_reg == 3'd1) && n < 100) begin tick(); n++; end
        tick();
        total++; if (ch_req !== 1'b1)      begin bad++; $display("FAIL rst_in_wait got=%b exp=1", ch_req); end
        total++; if (ch_sel !== 3'd3)      begin bad++; $display("FAIL rst_ch3 got=%0d exp=3", ch_sel); end
        total++; if (fifo_rdata !== 8'h30) begin bad++; $display("FAIL rst_head got=%h exp=30", fifo_rdata); end
        inst_rst = 1'b1; inst_readout = 1'b1;
        tick();
        inst_rst = 1'b0; inst_readout = 1'b0;
        total++; if (ch_req !== 1'b0)      begin bad++; $display("FAIL rst_req got=%b exp=0", ch_req); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (fifo_empty !== 1'b1)  begin bad++; $display("FAIL rst_empty got=%b exp=1", fifo_empty); end
        total++; if (fifo_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h exp=00", fifo_rdata); end
        ack_block = 1'b0;
        repeat (2) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_stays_idle got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        int n;
        pop_en = 1'b1; readout_mask = 8'h05;
        pulse_readout();
        n = 0;
        while (ch_sel != 3'd2 && n < 200) begin tick(); n++; end
        repeat (2) tick();
        total++; if (ch_sel !== 3'd2) begin bad++; $display("FAIL ar_pre_ch got=%0d exp=2", ch_sel); end
        #2;
        rstn = 1'b0;
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
        total++; if (ch_req !== 1'b0)      begin bad++; $display("FAIL ar_req got=%b exp=0", ch_req); end
        total++; if (ch_sel !== 3'd0)      begin bad++; $display("FAIL ar_ch_sel got=%0d exp=0", ch_sel); end
        total++; if (select_reg !== 3'd0)  begin bad++; $display("FAIL ar_sel got=%0d exp=0", select_reg); end
        total++; if (fifo_empty !== 1'b1)  begin bad++; $display("FAIL ar_empty got=%b exp=1", fifo_empty); end
        total++; if (fifo_rdata !== 8'h00) begin bad++; $display("FAIL ar_rdata got=%h exp=00", fifo_rdata); end
        tick();
        rstn = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_idle_after got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_mask05();
        test_empty_mask();
        test_cmd_err();
        test_stall();
        test_inst_rst();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psec6_readout_sequencer.md
Name: psec6_readout_sequencer

Overview:
Sequences readout of the per-channel counters after an acquisition stops. On an accepted inst_readout pulse it walks every enabled channel and every counter index, steering ch_sel and select_reg, and fetches each 16-bit word from channel digital with a req/ack handshake. Each word goes into a byte FIFO that the SPI read path drains one byte per pop. It sits between the SPI register/instruction block and the eight channel digital blocks, and runs on the SPI clock domain.

Parameters:
NUM_CH, 8, number of channels walked; ch_sel width is 3.
NUM_SEL, 5, counters per channel; select_reg runs 0..NUM_SEL-1.
WORD_W, 16, counter word width; fixed at 2 bytes.
FIFO_DEPTH, 4, byte FIFO depth; must be a power of 2.

Ports:
spi_clk  in  1  sole clock, rising edge
rstn  in  1  asynchronous active-low reset
inst_readout  in  1  one-cycle readout command pulse
inst_rst  in  1  one-cycle abort/flush pulse
clk_enable  in  1  acquisition running; readout is refused while high
readout_mask  in  NUM_CH  channel enable; bit i set means channel i is read
ch_sel  out  3  channel currently addressed
select_reg  out  3  counter index currently addressed
ch_req  out  1  word request to the addressed channel
ch_ack  in  1  channel word valid
ch_data  in  WORD_W  counter word, sampled when ch_ack=1
fifo_pop  in  1  SPI consumes the head byte
fifo_rdata  out  8  head byte; 0 when the FIFO is empty
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
busy  out  1  sequence in progress
done  out  1  sticky: the last sequence completed
cmd_err  out  1  sticky: a readout was refused

Behaviour:
- Reset (rstn=0, async): state IDLE; ch_sel=0, select_reg=0, ch_req=0, busy=0, done=0, cmd_err=0; FIFO flushed (fifo_empty=1, fifo_full=0, fifo_rdata=0).
- States: IDLE, FIND, REQ, WAIT_ACK, PUSH_HI, PUSH_LO, NEXT, DONE.
- IDLE -> FIND when inst_readout=1, clk_enable=0 and busy=0.
  - On this transition: clear done and cmd_err, set busy, set ch_sel=0, set select_reg=0.
  - inst_readout with clk_enable=1: stay IDLE, set cmd_err. Nothing else changes.
- FIND scans ch_sel upward from its current value to the lowest enabled channel, one cycle per check.
  - Enabled channel found -> REQ.
  - No enabled channel at or above ch_sel -> DONE. An all-zero mask therefore reaches DONE.
- REQ: wait until ch_ack=0, then assert ch_req and go to WAIT_ACK.
- WAIT_ACK: ch_req held high until ch_ack=1. On that edge, latch ch_data, drop ch_req, go to PUSH_HI.
- PUSH_HI pushes data[15:8]; PUSH_LO then pushes data[7:0]. MSB byte first.
  - Each push happens only in a cycle where fifo_full=0; otherwise the state stalls.
  - Pop and push in the same cycle while full: the pop completes, and the push retries next cycle.
- NEXT:
  - If select_reg < NUM_SEL-1: increment select_reg, -> REQ.
  - Else: select_reg=0, ch_sel+1, -> FIND.
  - ch_sel=NUM_CH-1 with the last index -> DONE without wrapping.
- DONE: busy=0, done=1, ch_sel and select_reg return to 0, -> IDLE.
  - done stays set until the next accepted readout or inst_rst.
  - The FIFO keeps unread bytes.
- Latency: inst_readout at edge N gives busy=1 after N. If channel 0 is enabled and ch_ack=0, ch_req=1 after N+2.
- FIFO:
  - fifo_rdata is combinational from the head entry.
  - fifo_pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy count provides full/empty.
- inst_rst (synchronous, in any state) has priority over every other event in that cycle:
  - state -> IDLE; ch_req=0, busy=0, done=0, cmd_err=0; FIFO flushed.
  - Simultaneous inst_readout is ignored.
- inst_readout while busy=1: ignored; cmd_err is not set.
- clk_enable rising mid-sequence: ignored; the sequence completes.
- Total bytes per sequence = 2 * popcount(readout_mask) * NUM_SEL.

Test Plan:
- mask=8'h05, clk_enable=0, pop every cycle the FIFO is non-empty; each ack returns 16'h{ch,sel}A5 -> 20 bytes in order 0x00,0xA5,0x01,0xA5,...; done=1, busy=0 at end.
- mask=8'h00, pulse inst_readout -> no ch_req; done=1 within 3 cycles; FIFO stays empty.
- clk_enable=1, pulse inst_readout -> cmd_err=1, busy=0. Then clk_enable=0 and a valid readout -> cmd_err clears.
- mask=8'h80, no pops -> FIFO fills to 4 bytes with fifo_full=1; sequencer stalls in PUSH_HI with ch_req=0. Pops resume -> all 10 bytes arrive, none lost or duplicated.
- inst_rst asserted during WAIT_ACK of channel 3 -> next cycle ch_req=0, busy=0, fifo_empty=1, fifo_rdata=0.
- rstn pulsed low mid-sequence -> all outputs go to reset values immediately, before the next spi_clk edge.
